// File: rtl/fxp_pkg.sv
// ---------------------------------------------------------------------------
// fxp_pkg
//   Shared fixed-point definitions for the TinyQV ALU datapath: the default
//   operand width and fractional-bit count, the iteration count of the
//   bit-serial square root, and the square-root sequencer state encoding.
//   The multiplier and the ALU import this package as well.
// ---------------------------------------------------------------------------
package fxp_pkg;

  localparam int WIDTH = 32;
  localparam int FBITS = 16;

  // One root bit is resolved per iteration, and each iteration consumes two
  // radicand bits, so a (w+f)-bit scaled radicand needs (w+f)/2 iterations.
  function automatic int sqrt_iters(input int w, input int f);
    return (w + f) / 2;
  endfunction

  typedef enum logic {
    S_IDLE,
    S_CALC
  } sqrt_state_t;

endpackage

// File: rtl/fxp_sqrt_step.sv
// ---------------------------------------------------------------------------
// fxp_sqrt_step
//   One combinational iteration of the restoring digit-by-digit square root.
//   Two radicand bits are shifted from the top of x into the partial
//   remainder, a trial subtraction of {q, 01} decides the next root bit, and
//   the root accumulator is shifted left by one with that bit appended.
//   Kept separate so the datapath can be checked alone and later unrolled.
//
//   Ports:
//     ac     - partial remainder in      (WIDTH+2 bits)
//     x      - radicand shifter in       (XW bits)
//     q      - root accumulator in       (QW bits)
//     ac_nxt - partial remainder out
//     x_nxt  - radicand shifter out
//     q_nxt  - root accumulator out
// ---------------------------------------------------------------------------
module fxp_sqrt_step #(
  parameter int WIDTH = fxp_pkg::WIDTH,
  parameter int XW    = fxp_pkg::WIDTH + fxp_pkg::FBITS,
  parameter int QW    = (fxp_pkg::WIDTH + fxp_pkg::FBITS) / 2
) (
  input  logic [WIDTH+1:0] ac,
  input  logic [XW-1:0]    x,
  input  logic [QW-1:0]    q,
  output logic [WIDTH+1:0] ac_nxt,
  output logic [XW-1:0]    x_nxt,
  output logic [QW-1:0]    q_nxt
);
  import fxp_pkg::*;

  logic [WIDTH+1:0] ac_shift;
  logic [WIDTH+2:0] subtrahend;
  logic [WIDTH+2:0] trial;
  logic [1:0]       unused_ac_msbs;

  // The remainder never exceeds 2*root, so the top two bits of ac are always
  // zero before the shift and can be dropped without losing information.
  assign ac_shift       = {ac[WIDTH-1:0], x[XW-1 -: 2]};
  assign unused_ac_msbs = ac[WIDTH+1:WIDTH];

  // Subtraction is done one bit wider than ac so the MSB acts as the sign.
  assign subtrahend = {{(WIDTH + 1 - QW){1'b0}}, q, 2'b01};
  assign trial      = {1'b0, ac_shift} - subtrahend;

  assign x_nxt = {x[XW-3:0], 2'b00};

  // A non-negative trial result means the next root bit is one and the
  // remainder is replaced; otherwise the shifted remainder is kept as is.
  always_comb begin
    ac_nxt = ac_shift;
    q_nxt  = {q[QW-2:0], 1'b0};
    if (!trial[WIDTH+2]) begin
      ac_nxt = trial[WIDTH+1:0];
      q_nxt  = {q[QW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/fxp_sqrt_iter.sv
// ---------------------------------------------------------------------------
// fxp_sqrt_iter
//   Iterative unsigned fixed-point square root feeding the ALU result
//   register. The radicand is unsigned Q(WIDTH-FBITS).FBITS; root and
//   remainder are produced one root bit per clock after an accepted start.
//     root = floor(sqrt(rad * 2^FBITS))   (Q.FBITS)
//     rem  = rad * 2^FBITS - root^2
//
//   Ports:
//     clk   - clock
//     rst_n - synchronous active-low reset
//     start - request a computation (may be held high)
//     busy  - high while iterating
//     valid - one-cycle pulse when root/rem have just been updated
//     rad   - radicand, sampled only when start is accepted
//     root  - square root result, held between completions
//     rem   - remainder result, held between completions
// ---------------------------------------------------------------------------
module fxp_sqrt_iter #(
  parameter int WIDTH = fxp_pkg::WIDTH,
  parameter int FBITS = fxp_pkg::FBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  input  logic [WIDTH-1:0] rad,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem
);
  import fxp_pkg::*;

  localparam int XW   = WIDTH + FBITS;
  localparam int ITER = sqrt_iters(WIDTH, FBITS);
  localparam int QW   = ITER;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  // Reject parameter sets the datapath cannot represent.
  if ((XW % 2) != 0) begin : g_bad_parity
    $error("fxp_sqrt_iter: WIDTH+FBITS must be even");
  end
  if (FBITS > WIDTH) begin : g_bad_fbits
    $error("fxp_sqrt_iter: FBITS must not exceed WIDTH");
  end

  sqrt_state_t      state;
  sqrt_state_t      state_d;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [XW-1:0]    x;
  logic [QW-1:0]    q;
  logic [WIDTH+1:0] ac;
  logic [XW-1:0]    x_nxt;
  logic [QW-1:0]    q_nxt;
  logic [WIDTH+1:0] ac_nxt;

  fxp_sqrt_step #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .QW    (QW)
  ) u_step (
    .ac     (ac),
    .x      (x),
    .q      (q),
    .ac_nxt (ac_nxt),
    .x_nxt  (x_nxt),
    .q_nxt  (q_nxt)
  );

  // Next-state logic: leave IDLE on start, return once the final iteration
  // is being committed. start is ignored while CALC is running.
  always_comb begin
    state_d = state;
    last    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        if (cnt == CW'(ITER - 1)) begin
          last    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register. A reset during CALC simply drops the operation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Datapath and outputs. The radicand is loaded pre-scaled by 2^FBITS so a
  // plain integer square root yields a Q.FBITS root. valid is a one-cycle
  // pulse, so it is cleared on every edge unless this edge completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      x     <= '0;
      q     <= '0;
      ac    <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      root  <= '0;
      rem   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x    <= XW'(rad) << FBITS;
            q    <= '0;
            ac   <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        S_CALC: begin
          x   <= x_nxt;
          q   <= q_nxt;
          ac  <= ac_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            root  <= WIDTH'(q_nxt);
            rem   <= ac_nxt[WIDTH-1:0];
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
